digitron_scan: RTL and testbench

DIGITRON_SCAN -- requirements
Module: digitron_scan

---
 rtl/digitron_scan_if.sv | 20 ++
 rtl/digitron_scan.sv | 173 +++++++++++++++++
 tb/tb_digitron_scan.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/digitron_scan_if.sv
// Display bus for digitron_scan: value to show, decimal-point and edit masks in;
// active-low segment/select drive and conversion strobe out.
interface digitron_scan_if;
  logic [19:0] number_on_digitron;
  logic [5:0]  point_position;
  logic [5:0]  shank_position;
  logic [7:0]  seg;
  logic [5:0]  sel;
  logic        conv_done;

  modport master (
    output number_on_digitron, point_position, shank_position,
    input  seg, sel, conv_done
  );

  modport slave (
    input  number_on_digitron, point_position, shank_position,
    output seg, sel, conv_done
  );
endinterface

// File: rtl/digitron_scan.sv
// Six-digit multiplexed 7-segment driver with a continuously running binary-to-BCD
// converter. Optional edit-digit blinking is built when DIGITRON_BLINK_EN is defined.
module digitron_scan #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 250
) (
  input  logic            clk,
  input  logic            rst_n,
  digitron_scan_if.slave  bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] SCAN_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t      state_reg, state_next;
  logic [19:0] shift_reg, shift_next;
  logic [23:0] bcd_reg, bcd_next;
  logic [4:0]  iter_reg, iter_next;
  logic        ovf_pend_reg, ovf_pend_next;
  logic [23:0] display_reg, display_next;
  logic        ovf_reg, ovf_next;
  logic        conv_done_reg, conv_done_next;
  logic [23:0] bcd_adj;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                  bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bcd_next       = bcd_reg;
    iter_next      = iter_reg;
    ovf_pend_next  = ovf_pend_reg;
    display_next   = display_reg;
    ovf_next       = ovf_reg;
    conv_done_next = 1'b0;
    case (state_reg)
      IDLE: begin
        shift_next    = bus.number_on_digitron;
        bcd_next      = 24'd0;
        iter_next     = 5'd0;
        ovf_pend_next = (bus.number_on_digitron > 20'd999999);
        state_next    = CONV;
      end
      CONV: begin
        {bcd_next, shift_next} = {bcd_adj[22:0], shift_reg, 1'b0};
        iter_next = iter_reg + 5'd1;
        if (iter_reg == 5'd19) state_next = LOAD;
      end
      LOAD: begin
        display_next   = bcd_reg;
        ovf_next       = ovf_pend_reg;
        conv_done_next = 1'b1;
        state_next     = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= 20'd0;
      bcd_reg       <= 24'd0;
      iter_reg      <= 5'd0;
      ovf_pend_reg  <= 1'b0;
      display_reg   <= 24'd0;
      ovf_reg       <= 1'b0;
      conv_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bcd_reg       <= bcd_next;
      iter_reg      <= iter_next;
      ovf_pend_reg  <= ovf_pend_next;
      display_reg   <= display_next;
      ovf_reg       <= ovf_next;
      conv_done_reg <= conv_done_next;
    end
  end

  logic [PW-1:0] presc_reg;
  logic [2:0]    index_reg;
  logic [7:0]    seg_reg, seg_next;
  logic [5:0]    sel_reg, sel_next;
  logic          tick;
  logic [3:0]    digit [6];
  logic [3:0]    cur_digit;

  assign tick = (presc_reg == SCAN_LAST);

  // Digit 0 is the most significant nibble of the display register
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      assign digit[gi] = display_reg[23 - 4*gi -: 4];
    end
  endgenerate

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

`ifdef DIGITRON_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_phase_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (tick) begin
      if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (index_reg == 3'(i)) cur_digit = digit[i];
    end
    sel_next      = ~(6'b000001 << index_reg);
    seg_next[6:0] = ovf_reg ? 7'h3F : seg_code(cur_digit);
    seg_next[7]   = ~bus.point_position[index_reg];
`ifdef DIGITRON_BLINK_EN
    if (blink_phase_reg && bus.shank_position[index_reg]) seg_next = 8'hFF;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      index_reg <= 3'd0;
      seg_reg   <= 8'hFF;
      sel_reg   <= 6'b111111;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + 1'b1;
      if (tick) index_reg <= (index_reg == 3'd5) ? 3'd0 : index_reg + 3'd1;
      seg_reg <= seg_next;
      sel_reg <= sel_next;
    end
  end

  assign bus.seg       = seg_reg;
  assign bus.sel       = sel_reg;
  assign bus.conv_done = conv_done_reg;

endmodule

// File: tb/tb_digitron_scan.sv
// Bench for digitron_scan: arithmetic reference model checked every cycle, plus
// table vectors and hand sequences for conversion latency, in-flight changes and reset.
module tb_digitron_scan;
  localparam int SD = 4;
  localparam int BD = 3;
`ifdef DIGITRON_BLINK_EN
  localparam bit EXP_BLINK = 1'b1;
`else
  localparam bit EXP_BLINK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  digitron_scan_if bus ();

  digitron_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference: digit i of the value is (v / 10^(5-i)) % 10
  function automatic logic [7:0] model_seg(input int disp, input bit ovf, input int idx,
                                           input logic [5:0] pt, input logic [5:0] sk,
                                           input int phase);
    logic [7:0] codes [10];
    logic [7:0] s;
    logic [2:0] i3;
    int p;
    codes = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    i3 = 3'(idx);
    p = 1;
    for (int k = 0; k < 5 - idx; k++) p *= 10;
    s = ovf ? 8'hBF : codes[(disp / p) % 10];
    if (pt[i3]) s[7] = 1'b0;
    if (EXP_BLINK && phase == 1 && sk[i3]) s = 8'hFF;
    return s;
  endfunction

  int         n;
  int         m_samp, m_disp;
  bit         m_ovf;
  logic [7:0] exp_seg;
  logic [5:0] exp_sel;
  logic       exp_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_samp = 0; m_disp = 0; m_ovf = 1'b0;
      exp_seg = 8'hFF; exp_sel = 6'h3F; exp_done = 1'b0;
    end else begin
      int idx;
      n++;
      idx = ((n - 1) / SD) % 6;
      exp_sel  = ~(6'b000001 << idx);
      exp_seg  = model_seg(m_disp, m_ovf, idx, bus.point_position, bus.shank_position,
                           (((n - 1) / SD) / BD) % 2);
      exp_done = (n % 22 == 0);
      if (n % 22 == 1) m_samp = int'(bus.number_on_digitron);
      if (n % 22 == 0) begin
        m_disp = m_samp;
        m_ovf  = (m_samp > 999999);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cont_sel", 32'(bus.sel), 32'(exp_sel));
      check("cont_seg", 32'(bus.seg), 32'(exp_seg));
      check("cont_done", 32'(bus.conv_done), 32'(exp_done));
    end
  end

  task automatic wait_done();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.conv_done === 1'b1) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_done_timeout got=0 exp=1");
  endtask

  // Call right after conv_done is seen: 21 cycles see every slot of the new load
  task automatic check_digits(input string name, input logic [47:0] exp);
    bit seen [6];
    logic [5:0] oh;
    for (int d = 0; d < 6; d++) seen[d] = 1'b0;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      for (int d = 0; d < 6; d++) begin
        oh = ~(6'b000001 << d);
        if (bus.sel === oh && !seen[d]) begin
          seen[d] = 1'b1;
          check(name, 32'(bus.seg), 32'(exp[47 - 8*d -: 8]));
        end
      end
    end
    for (int d = 0; d < 6; d++) begin
      if (!seen[d]) begin
        checks++;
        failures++;
        $display("FAIL %s_slot%0d got=unseen exp=seen", name, d);
      end
    end
    $display("xact %s digits checked", name);
  endtask

  typedef struct {
    logic [19:0] value;
    logic [5:0]  point;
    logic [47:0] segs;
    string       name;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int e;
    int ff_seen, ok_seen;
    vecs[0] = '{20'd50,      6'b000000, {8'hC0,8'hC0,8'hC0,8'hC0,8'h92,8'hC0}, "v50"};
    vecs[1] = '{20'd999999,  6'b000000, {8'h90,8'h90,8'h90,8'h90,8'h90,8'h90}, "v999999"};
    vecs[2] = '{20'd1000000, 6'b000000, {8'hBF,8'hBF,8'hBF,8'hBF,8'hBF,8'hBF}, "v1000000"};
    vecs[3] = '{20'd25000,   6'b000000, {8'hC0,8'hA4,8'h92,8'hC0,8'hC0,8'hC0}, "v25000"};
    vecs[4] = '{20'd12345,   6'b000000, {8'hC0,8'hF9,8'hA4,8'hB0,8'h99,8'h92}, "v12345"};
    vecs[5] = '{20'd0,       6'b000100, {8'hC0,8'hC0,8'h40,8'hC0,8'hC0,8'hC0}, "vpoint2"};
    vecs[6] = '{20'd678901,  6'b100001, {8'h02,8'hF8,8'h80,8'h90,8'hC0,8'h79}, "v678901"};
    vecs[7] = '{20'd1048575, 6'b000001, {8'h3F,8'hBF,8'hBF,8'hBF,8'hBF,8'hBF}, "vmaxovf"};

    bus.number_on_digitron = 20'd50;
    bus.point_position     = 6'b000000;
    bus.shank_position     = 6'b000000;
    repeat (3) @(posedge clk);
    #2;
    check("reset_sel", 32'(bus.sel), 32'h3F);
    check("reset_seg", 32'(bus.seg), 32'hFF);
    check("reset_done", 32'(bus.conv_done), 32'h0);
    chk_en = 1'b1;

    // Release and measure first-load latency
    @(posedge clk); #2 rst_n = 1'b1;
    for (e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.conv_done === 1'b1) break;
    end
    check("first_done_cycle", 32'(e), 32'd22);
    check_digits("n50", vecs[0].segs);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.number_on_digitron = vecs[i].value;
      bus.point_position     = vecs[i].point;
      wait_done();
      wait_done();
      check_digits(vecs[i].name, vecs[i].segs);
    end
    bus.point_position = 6'b000000;

    // Input change while a conversion is in flight
    wait_done();
    bus.number_on_digitron = 20'd12345;
    repeat (6) @(negedge clk);
    bus.number_on_digitron = 20'd54321;
    wait_done();
    check_digits("inflight_12345", {8'hC0,8'hF9,8'hA4,8'hB0,8'h99,8'h92});
    wait_done();
    check_digits("next_54321", {8'hC0,8'h92,8'h99,8'hB0,8'hA4,8'hF9});

    // Edit-digit blinking on digit 5
    @(negedge clk);
    bus.number_on_digitron = 20'd0;
    bus.shank_position     = 6'b100000;
    wait_done();
    wait_done();
    ff_seen = 0;
    ok_seen = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.sel === 6'b011111) begin
        if (bus.seg === 8'hFF) ff_seen++;
        else if (bus.seg === 8'hC0) ok_seen++;
      end
    end
    check("blink_d5_ff_seen", 32'(ff_seen > 0), 32'(EXP_BLINK));
    check("blink_d5_valid_seen", 32'(ok_seen > 0), 32'd1);
    $display("xact blink ff_slots=%0d valid_slots=%0d", ff_seen, ok_seen);
    bus.shank_position = 6'b000000;

    // Reset pulse around CONV iteration 10
    bus.number_on_digitron = 20'd777;
    wait_done();
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_sel", 32'(bus.sel), 32'h3F);
    check("midreset_seg", 32'(bus.seg), 32'hFF);
    check("midreset_done", 32'(bus.conv_done), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (e = 1; e <= 40; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.conv_done === 1'b1) break;
    end
    check("midreset_done_cycle", 32'(e), 32'd22);
    check_digits("after_reset_777", {8'hC0,8'hC0,8'hC0,8'hF8,8'hF8,8'hF8});

    // Randomized traffic, checked cycle by cycle against the model
    for (int t = 0; t < 40; t++) begin
      int r;
      logic [19:0] v;
      r = int'($urandom_range(0, 3));
      case (r)
        0:       v = 20'($urandom_range(0, 1048575));
        1:       v = 20'($urandom_range(999990, 1000010));
        2:       v = 20'($urandom_range(0, 999));
        default: v = 20'($urandom_range(0, 999999));
      endcase
      @(negedge clk);
      bus.number_on_digitron = v;
      bus.point_position     = 6'($urandom_range(0, 63));
      bus.shank_position     = 6'($urandom_range(0, 63));
      $display("xact random value=%0d point=%b shank=%b", v, bus.point_position, bus.shank_position);
      repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
